gate_sweep_unit: RTL and testbench
==================================

// Module: gate_sweep_unit
// PURPOSE
// - Parametrised N-input logic gate (AND/OR/NAND/NOR) with a built-in exhaustive sweep sequencer.
// - On start, steps through all 2^WIDTH input vectors and streams (vector, gate result) out over a valid/ready handshake.
// - Counts result-ones and signals completion.
// - Next generation of the fixed 3-input AND gate and its hand-written truth-table bench; used for self-checking gate exercises.
// PARAMETERS
// - WIDTH  3  number of gate inputs; legal 1..16; sweep length = 2^WIDTH vectors
// PORTS
// - clk        in   1        rising-edge clock; single clock domain
// - rst_n      in   1        reset, asynchronous assert, active-low
// - start      in   1        begin sweep; sampled only in IDLE
// - op         in   2        gate select, sampled with start: 00 AND, 01 OR, 10 NAND, 11 NOR
// - vec        out  WIDTH    current input vector presented to the gate
// - res        out  1        gate result for vec under the latched op
// - res_valid  out  1        vec/res valid this cycle
// - res_ready  in   1        consumer accepts vec/res when res_valid & res_ready
// - busy       out  1        high in RUN and DONE
// - done       out  1        one-cycle pulse after the last vector is accepted
// - ones_count out  WIDTH+1  number of accepted beats with res=1 in the current/last sweep
// BEHAVIOUR
// - Reset (rst_n=0, takes effect immediately without a clock edge):
//   - state=IDLE; vec, res_valid, busy, done, ones_count=0; op_q=00.
// - FSM states: IDLE, RUN, DONE.
//   - IDLE: start=1 at an edge -> op_q<=op, vec<=0, ones_count<=0, state<=RUN.
//     res_valid, busy and done are 0.
//   - RUN: res_valid=1, busy=1.
//     - Handshake edge (res_ready=1): ones_count += res.
//     - If vec == all-ones -> state<=DONE (vec holds); else vec<=vec+1.
//     - res_ready=0: vec, res and ones_count hold stable; no beat is lost or duplicated.
//   - DONE: done=1, busy=1, res_valid=0 for exactly one cycle -> IDLE.
// - res is combinational from registered vec and op_q:
//   - AND = &vec; OR = |vec; NAND = ~&vec; NOR = ~|vec.
// - ones_count holds its final value in IDLE until the next accepted start.
// - start while busy is ignored; op changes while busy are ignored; op_q is fixed per sweep.
// - Latency: start accepted at edge k -> first beat (vec=0) valid in cycle k+1.
//   - With res_ready tied 1, the last beat is at cycle k+2^WIDTH and done is at cycle k+2^WIDTH+1.
// - vec never wraps; the sweep terminates at all-ones, with no restart without a new start.
// - ones_count width WIDTH+1 holds the maximum of 2^WIDTH without overflow.
// - Reset mid-sweep aborts immediately; there is no done pulse, and the next start restarts from vec=0.
// - No combinational path from res_ready or start to any output.
// STRUCTURE
// - Shared package gate_sweep_pkg:
//   - op encodings OP_AND/OP_OR/OP_NAND/OP_NOR (2-bit);
//   - state encodings ST_IDLE/ST_RUN/ST_DONE (2-bit).
// - One sub-module: gate_nway (parameter WIDTH; inputs a[WIDTH-1:0], op[1:0]; output s).
//   - Purely combinational reduction; directly replaces the fixed 3-input AND gate.
// - The top holds the FSM, the vec counter, op_q and the ones accumulator.
// TESTING
// - T1: WIDTH=3, op=00, res_ready=1, pulse start.
//   - Expect vec 000..111 on 8 consecutive beats, res=1 only at 111.
//   - done one cycle after 111; ones_count=1.
// - T2: WIDTH=3, op=01, res_ready=1.
//   - Expect res=0 only at 000; ones_count=7; then run op=11, expect ones_count=1.
// - T3: WIDTH=4, op=10, res_ready random 50%.
//   - Expect 16 accepted beats in order 0..15 with no duplicates; ones_count=15; exactly one done pulse.
// - T4: Backpressure: hold res_ready=0 for 3 cycles while vec=010.
//   - Expect vec=010, res stable and ones_count unchanged; sweep resumes at 011.
// - T5: Reset mid-sweep: assert rst_n=0 between edges at vec=101.
//   - Expect vec=0, res_valid=0, busy=0, ones_count=0 immediately; no done; new start restarts at 000.
// - T6: start pulse while busy, with op changed to 11.
//   - Expect it to be ignored: the sweep continues with the original op, and there is no restart.

Source files
------------

// File: rtl/gate_sweep_pkg.sv
// Shared encodings for the gate sweep unit: gate operations and FSM states.
package gate_sweep_pkg;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_NAND = 2'b10;
  localparam logic [1:0] OP_NOR  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/gate_sweep_unit_gate_nway.sv
// N-input AND/OR/NAND/NOR reduction gate, purely combinational.
module gate_nway
  import gate_sweep_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic [WIDTH-1:0] a,
  input  logic [1:0]       op,
  output logic             s
);

  always_comb begin
    s = 1'b0;
    case (op)
      OP_AND:  s = &a;
      OP_OR:   s = |a;
      OP_NAND: s = ~&a;
      default: s = ~|a;
    endcase
  end

endmodule

// File: rtl/gate_sweep_unit.sv
// Exhaustive sweep of a WIDTH-input gate: streams every input vector and its
// result over valid/ready, counts accepted ones, and pulses done at the end.
module gate_sweep_unit
  import gate_sweep_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] vec,
  output logic             res,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   ones_count
);

  localparam int unsigned CW = WIDTH + 1;
  localparam logic [WIDTH-1:0] VEC_LAST = '1;

  logic [1:0]       state, state_nxt;
  logic [1:0]       op_q, op_nxt;
  logic [WIDTH-1:0] vec_nxt;
  logic [CW-1:0]    ones_nxt;
  logic             res_valid_nxt, busy_nxt, done_nxt;

  gate_nway #(.WIDTH(WIDTH)) u_gate (
    .a  (vec),
    .op (op_q),
    .s  (res)
  );

  // Flags are computed for the state being entered so they leave a flop.
  always_comb begin
    state_nxt     = state;
    op_nxt        = op_q;
    vec_nxt       = vec;
    ones_nxt      = ones_count;
    res_valid_nxt = 1'b0;
    busy_nxt      = 1'b0;
    done_nxt      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          op_nxt        = op;
          vec_nxt       = '0;
          ones_nxt      = '0;
          state_nxt     = ST_RUN;
          res_valid_nxt = 1'b1;
          busy_nxt      = 1'b1;
        end
      end
      ST_RUN: begin
        res_valid_nxt = 1'b1;
        busy_nxt      = 1'b1;
        if (res_ready) begin
          ones_nxt = ones_count + CW'(res);
          if (vec == VEC_LAST) begin
            state_nxt     = ST_DONE;
            res_valid_nxt = 1'b0;
            done_nxt      = 1'b1;
          end else begin
            vec_nxt = vec + WIDTH'(1);
          end
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      op_q       <= OP_AND;
      vec        <= '0;
      ones_count <= '0;
      res_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      op_q       <= op_nxt;
      vec        <= vec_nxt;
      ones_count <= ones_nxt;
      res_valid  <= res_valid_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

endmodule

// File: tb/tb_gate_sweep_unit.sv
// Bench for gate_sweep_unit: a 3-input and a 4-input instance driven through
// table-driven and random sweeps, checked against a counting reference model.
module tb_gate_sweep_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       sel;
  logic [1:0] op;
  logic       res_ready;

  logic       start_a, start_b;
  logic [2:0] vec_a;
  logic [3:0] vec_b;
  logic       res_a, res_b, valid_a, valid_b, busy_a, busy_b, done_a, done_b;
  logic [3:0] ones_a;
  logic [4:0] ones_b;

  logic [15:0] cur_vec;
  logic [16:0] cur_ones;
  logic        cur_res, cur_valid, cur_busy, cur_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  assign cur_vec   = sel ? 16'(vec_b) : 16'(vec_a);
  assign cur_ones  = sel ? 17'(ones_b) : 17'(ones_a);
  assign cur_res   = sel ? res_b : res_a;
  assign cur_valid = sel ? valid_b : valid_a;
  assign cur_busy  = sel ? busy_b : busy_a;
  assign cur_done  = sel ? done_b : done_a;

  gate_sweep_unit #(.WIDTH(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .op(op),
    .vec(vec_a), .res(res_a), .res_valid(valid_a), .res_ready(res_ready),
    .busy(busy_a), .done(done_a), .ones_count(ones_a)
  );

  gate_sweep_unit #(.WIDTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .op(op),
    .vec(vec_b), .res(res_b), .res_valid(valid_b), .res_ready(res_ready),
    .busy(busy_b), .done(done_b), .ones_count(ones_b)
  );

  typedef struct {
    logic       s;
    logic [1:0] o;
    int         rdy_pct;
    int         inject;
    int         exp_ones;
    string      nm;
  } sweep_t;

  // Reference gate from the truth-table definition of each operation.
  function automatic int gate_ref(input logic [1:0] o, input int v, input int w);
    int all_ones;
    all_ones = (1 << w) - 1;
    case (o)
      2'b00:   return (v == all_ones) ? 1 : 0;
      2'b01:   return (v != 0) ? 1 : 0;
      2'b10:   return (v != all_ones) ? 1 : 0;
      default: return (v == 0) ? 1 : 0;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one full sweep from IDLE, optionally pulsing start with op=NOR at beat 'inject'.
  task automatic sweep(input sweep_t t);
    int  w, n, ev, mones, cyc;
    bit  inj_done, rdy;
    w = t.s ? 4 : 3;
    n = 1 << w;
    ev = 0; mones = 0; cyc = 0; inj_done = 0;
    sel = t.s; op = t.o; res_ready = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    while (ev < n && cyc < 500) begin
      check({t.nm, ".valid"}, 32'(cur_valid), 32'd1);
      check({t.nm, ".vec"},   32'(cur_vec),   32'(ev));
      check({t.nm, ".res"},   32'(cur_res),   32'(gate_ref(t.o, ev, w)));
      check({t.nm, ".ones"},  32'(cur_ones),  32'(mones));
      check({t.nm, ".done"},  32'(cur_done),  32'd0);
      if (!inj_done && ev == t.inject) begin
        start = 1'b1; op = 2'b11; inj_done = 1;
      end else begin
        start = 1'b0; op = t.o;
      end
      rdy = ($urandom_range(0, 99) < t.rdy_pct);
      res_ready = rdy;
      step();
      if (rdy) begin
        mones += gate_ref(t.o, ev, w);
        ev++;
      end
      cyc++;
    end
    start = 1'b0; op = t.o; res_ready = 1'($urandom_range(0, 1));
    if (ev < n) check({t.nm, ".timeout"}, 32'(ev), 32'(n));
    check({t.nm, ".done_pulse"}, 32'(cur_done),  32'd1);
    check({t.nm, ".done_busy"},  32'(cur_busy),  32'd1);
    check({t.nm, ".done_valid"}, 32'(cur_valid), 32'd0);
    check({t.nm, ".final_ones"}, 32'(cur_ones),  32'(t.exp_ones));
    check({t.nm, ".model_ones"}, 32'(cur_ones),  32'(mones));
    step();
    check({t.nm, ".done_drop"},  32'(cur_done),  32'd0);
    check({t.nm, ".idle_busy"},  32'(cur_busy),  32'd0);
    check({t.nm, ".ones_hold"},  32'(cur_ones),  32'(t.exp_ones));
    step();
    check({t.nm, ".no_restart"}, 32'(cur_busy),  32'd0);
    check({t.nm, ".vec_hold"},   32'(cur_vec),   32'(n - 1));
  endtask

  sweep_t tbl[8];

  initial begin
    bit seen_done;
    int n_exp;
    sweep_t r;

    tbl[0] = '{1'b0, 2'b00, 100, -1,  1, "t1_and3"};
    tbl[1] = '{1'b0, 2'b01, 100, -1,  7, "t2_or3"};
    tbl[2] = '{1'b0, 2'b11, 100, -1,  1, "t2_nor3"};
    tbl[3] = '{1'b0, 2'b10, 100, -1,  7, "nand3"};
    tbl[4] = '{1'b1, 2'b10,  50, -1, 15, "t3_nand4"};
    tbl[5] = '{1'b1, 2'b00,  50, -1,  1, "and4_bp"};
    tbl[6] = '{1'b0, 2'b00, 100,  3,  1, "t6_start_busy"};
    tbl[7] = '{1'b1, 2'b01,  30,  5, 15, "t6_or4_bp"};

    rst_n = 1'b0; start = 1'b0; sel = 1'b0; op = 2'b00; res_ready = 1'b0;
    step();
    step();
    check("rst.vec_a",   32'(vec_a),   32'd0);
    check("rst.valid_a", 32'(valid_a), 32'd0);
    check("rst.busy_a",  32'(busy_a),  32'd0);
    check("rst.done_a",  32'(done_a),  32'd0);
    check("rst.ones_a",  32'(ones_a),  32'd0);
    check("rst.res_a",   32'(res_a),   32'd0);
    check("rst.vec_b",   32'(vec_b),   32'd0);
    check("rst.ones_b",  32'(ones_b),  32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) sweep(tbl[i]);

    // Backpressure held for three cycles at vec=010 under OR.
    sel = 1'b0; op = 2'b01; res_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("t4.vec_before", 32'(vec_a), 32'd2);
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4.vec_hold",  32'(vec_a),   32'd2);
      check("t4.res_hold",  32'(res_a),   32'd1);
      check("t4.ones_hold", 32'(ones_a),  32'd1);
      check("t4.valid",     32'(valid_a), 32'd1);
    end
    res_ready = 1'b1;
    step();
    check("t4.resume_vec",  32'(vec_a),  32'd3);
    check("t4.resume_ones", 32'(ones_a), 32'd2);
    seen_done = 0;
    for (int i = 0; i < 20 && !seen_done; i++) begin
      step();
      seen_done = done_a;
    end
    check("t4.done_seen", 32'(seen_done), 32'd1);
    check("t4.final_ones", 32'(ones_a), 32'd7);
    step();

    // Reset asserted between edges in the middle of a sweep.
    sel = 1'b0; op = 2'b00; res_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    check("t5.vec_pre", 32'(vec_a), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check("t5.vec",   32'(vec_a),   32'd0);
    check("t5.valid", 32'(valid_a), 32'd0);
    check("t5.busy",  32'(busy_a),  32'd0);
    check("t5.ones",  32'(ones_a),  32'd0);
    check("t5.done",  32'(done_a),  32'd0);
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5.no_done", 32'(done_a), 32'd0);
      check("t5.idle",    32'(busy_a), 32'd0);
    end
    r = '{1'b0, 2'b00, 100, -1, 1, "t5_restart"};
    sweep(r);

    // Random sweeps; expected count enumerated from the reference gate.
    for (int k = 0; k < 4; k++) begin
      r.s = 1'($urandom_range(0, 1));
      r.o = 2'($urandom_range(0, 3));
      r.rdy_pct = $urandom_range(20, 100);
      r.inject = -1;
      n_exp = 0;
      for (int v = 0; v < (r.s ? 16 : 8); v++) n_exp += gate_ref(r.o, v, r.s ? 4 : 3);
      r.exp_ones = n_exp;
      r.nm = $sformatf("rand%0d", k);
      sweep(r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
